// File: rtl/gshare_btb_if.sv
// Fetch-side lookup and resolution-side training signals shared between the
// core (master) and the gshare/BTB predictor (slave).
interface gshare_btb_if #(
    parameter int GHR_BITS = 5
) ();
    logic [31:0]         if_pc;
    logic [31:0]         pred_pc;
    logic                pred_taken;
    logic [GHR_BITS-1:0] pred_idx;
    logic                upd_valid;
    logic [31:0]         upd_pc;
    logic                upd_is_ctrl;
    logic                upd_is_cond;
    logic                upd_taken;
    logic [31:0]         upd_target;
    logic [GHR_BITS-1:0] upd_idx;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_is_ctrl, upd_is_cond,
               upd_taken, upd_target, upd_idx,
        input  pred_pc, pred_taken, pred_idx
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_is_ctrl, upd_is_cond,
               upd_taken, upd_target, upd_idx,
        output pred_pc, pred_taken, pred_idx
    );
endinterface

// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor with a tagged, direct-mapped BTB. Prediction is
// combinational from if_pc; training happens at resolution with the fetch-time PHT index.
module gshare_btb_predictor #(
    parameter int GHR_BITS    = 5,
    parameter int BTB_ENTRIES = 32
) (
    input  logic          clk,
    input  logic          reset,
    gshare_btb_if.slave   bus
);
    localparam int BTB_IDX     = $clog2(BTB_ENTRIES);
    localparam int TAG_W       = 32 - BTB_IDX - 2;
    localparam int PHT_ENTRIES = 1 << GHR_BITS;

    logic [BTB_ENTRIES-1:0] btb_valid_r;
    logic [BTB_ENTRIES-1:0] btb_uncond_r;
    logic [TAG_W-1:0]       btb_tag_r    [BTB_ENTRIES];
    logic [31:0]            btb_target_r [BTB_ENTRIES];
    logic [1:0]             pht_r        [PHT_ENTRIES];
    logic [GHR_BITS-1:0]    ghr_r;

    logic [BTB_IDX-1:0]     look_btb_idx_s;
    logic [TAG_W-1:0]       look_tag_s;
    logic [GHR_BITS-1:0]    look_pht_idx_s;
    logic                   look_hit_s;
    logic                   look_taken_s;
    logic [BTB_IDX-1:0]     upd_btb_idx_s;
    logic [TAG_W-1:0]       upd_tag_s;
    logic                   btb_wr_s;
    logic                   pht_wr_s;
    logic [GHR_BITS:0]      ghr_shift_s;
    logic                   unused_ok_s;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        case ({taken, cnt})
            3'b1_00: nxt = 2'b01;
            3'b1_01: nxt = 2'b10;
            3'b1_10: nxt = 2'b11;
            3'b1_11: nxt = 2'b11;
            3'b0_00: nxt = 2'b00;
            3'b0_01: nxt = 2'b00;
            3'b0_10: nxt = 2'b01;
            3'b0_11: nxt = 2'b10;
            default: nxt = 2'b01;
        endcase
        return nxt;
    endfunction

    assign unused_ok_s = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};

    // Lookup path: BTB hit plus PHT direction, or uncond entry, selects the target.
    always_comb begin
        look_btb_idx_s = bus.if_pc[BTB_IDX+1:2];
        look_tag_s     = bus.if_pc[31:BTB_IDX+2];
        look_pht_idx_s = bus.if_pc[GHR_BITS+1:2] ^ ghr_r;
        look_hit_s     = btb_valid_r[look_btb_idx_s] && (btb_tag_r[look_btb_idx_s] == look_tag_s);
        look_taken_s   = look_hit_s && (btb_uncond_r[look_btb_idx_s] || pht_r[look_pht_idx_s][1]);
        if (look_taken_s) begin
            bus.pred_pc = btb_target_r[look_btb_idx_s];
        end else begin
            bus.pred_pc = bus.if_pc + 32'd4;
        end
        bus.pred_taken = look_taken_s;
        bus.pred_idx   = look_pht_idx_s;
    end

    // Training decode; a cond branch flagged as non-control is still treated as control.
    always_comb begin
        upd_btb_idx_s = bus.upd_pc[BTB_IDX+1:2];
        upd_tag_s     = bus.upd_pc[31:BTB_IDX+2];
        btb_wr_s      = bus.upd_valid && (bus.upd_is_ctrl || bus.upd_is_cond) && bus.upd_taken;
        pht_wr_s      = bus.upd_valid && bus.upd_is_cond;
        ghr_shift_s   = {ghr_r, bus.upd_taken};
    end

    // Resettable predictor state: BTB valid/uncond flags, PHT counters, history.
    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid_r  <= {BTB_ENTRIES{1'b0}};
            btb_uncond_r <= {BTB_ENTRIES{1'b0}};
            ghr_r        <= {GHR_BITS{1'b0}};
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_r[i] <= 2'b01;
            end
        end else begin
            if (btb_wr_s) begin
                btb_valid_r[upd_btb_idx_s]  <= 1'b1;
                btb_uncond_r[upd_btb_idx_s] <= !bus.upd_is_cond;
            end
            if (pht_wr_s) begin
                pht_r[bus.upd_idx] <= sat_step(pht_r[bus.upd_idx], bus.upd_taken);
                ghr_r              <= ghr_shift_s[GHR_BITS-1:0];
            end
        end
    end

    // BTB payload; only meaningful behind a valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (btb_wr_s && !reset) begin
            btb_tag_r[upd_btb_idx_s]    <= upd_tag_s;
            btb_target_r[upd_btb_idx_s] <= bus.upd_target;
        end
    end
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench for gshare_btb_predictor: stimulus pushes hand-computed
// lookup expectations into a queue, a negedge monitor pops and compares.
module tb_gshare_btb_predictor;
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [4:0]  idx;
        logic [31:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic look_valid = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   look_id = 0;
    exp_t exp_q[$];

    gshare_btb_if #(.GHR_BITS(5)) bus ();

    gshare_btb_predictor #(.GHR_BITS(5), .BTB_ENTRIES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Monitor: every presented lookup is checked against the oldest expectation.
    always @(negedge clk) begin
        if (look_valid) begin
            exp_t e;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL lookup_unexpected pc=0x%08h no expectation queued", bus.if_pc);
            end else begin
                e = exp_q.pop_front();
                if (bus.pred_pc !== e.pc || bus.pred_taken !== e.taken || bus.pred_idx !== e.idx) begin
                    failures = failures + 1;
                    $display("FAIL lookup%0d if_pc=0x%08h got pc=0x%08h taken=%0b idx=0x%02h expected pc=0x%08h taken=%0b idx=0x%02h",
                             e.id, bus.if_pc, bus.pred_pc, bus.pred_taken, bus.pred_idx, e.pc, e.taken, e.idx);
                end
            end
        end
    end

    // One clock of stimulus: optional reset, optional training, optional lookup.
    task automatic step(input bit rst, input bit uv, input logic [31:0] upc, input bit ctrl,
                        input bit cond, input bit tk, input logic [31:0] tgt, input logic [4:0] uidx,
                        input bit lk, input logic [31:0] lpc, input logic [31:0] epc,
                        input bit etk, input logic [4:0] eidx);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst;
        bus.upd_valid   = uv;
        bus.upd_pc      = upc;
        bus.upd_is_ctrl = ctrl;
        bus.upd_is_cond = cond;
        bus.upd_taken   = tk;
        bus.upd_target  = tgt;
        bus.upd_idx     = uidx;
        bus.if_pc       = lpc;
        look_valid      = lk;
        if (lk) begin
            look_id = look_id + 1;
            e.pc = epc; e.taken = etk; e.idx = eidx; e.id = look_id;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0);
    endtask

    task automatic train(input logic [31:0] upc, input bit ctrl, input bit cond, input bit tk,
                         input logic [31:0] tgt, input logic [4:0] uidx);
        step(1'b0, 1'b1, upc, ctrl, cond, tk, tgt, uidx, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0);
    endtask

    task automatic look(input logic [31:0] lpc, input logic [31:0] epc, input bit etk, input logic [4:0] eidx);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'h0, 1'b1, lpc, epc, etk, eidx);
    endtask

    initial begin
        bus.if_pc = 32'h0; bus.upd_valid = 1'b0; bus.upd_pc = 32'h0; bus.upd_is_ctrl = 1'b0;
        bus.upd_is_cond = 1'b0; bus.upd_taken = 1'b0; bus.upd_target = 32'h0; bus.upd_idx = 5'h0;

        // T1: reset state and PC wrap
        do_reset();
        look(32'h0000_0100, 32'h0000_0104, 1'b0, 5'h00);
        look(32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 5'h1F);

        // T2: jal allocation; same-cycle lookup sees old state
        step(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 1'b1, 32'h80, 5'h00, 1'b1, 32'h20, 32'h24, 1'b0, 5'h08);
        look(32'h0000_0020, 32'h0000_0080, 1'b1, 5'h08);
        step(1'b0, 1'b0, 32'h24, 1'b1, 1'b0, 1'b1, 32'h300, 5'h00, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0);
        look(32'h0000_0024, 32'h0000_0028, 1'b0, 5'h09);
        train(32'h28, 1'b0, 1'b0, 1'b1, 32'h300, 5'h00);
        look(32'h0000_0028, 32'h0000_002C, 1'b0, 5'h0A);

        // T3: two taken cond updates, then not-taken and illegal-encoded cond
        do_reset();
        train(32'h40, 1'b1, 1'b1, 1'b1, 32'h10, 5'h13);
        train(32'h40, 1'b1, 1'b1, 1'b1, 32'h10, 5'h13);
        look(32'h0000_0040, 32'h0000_0010, 1'b1, 5'h13);
        train(32'h44, 1'b1, 1'b1, 1'b0, 32'h500, 5'h00);
        look(32'h0000_0044, 32'h0000_0048, 1'b0, 5'h17);
        train(32'h48, 1'b0, 1'b1, 1'b1, 32'h600, 5'h00);
        look(32'h0000_0048, 32'h0000_004C, 1'b0, 5'h1F);

        // T4: counter floors at 00, one taken brings it to 01 only
        do_reset();
        for (int i = 0; i < 4; i++) train(32'h60, 1'b1, 1'b1, 1'b0, 32'h0, 5'h05);
        train(32'h10, 1'b1, 1'b1, 1'b1, 32'h300, 5'h05);
        look(32'h0000_0010, 32'h0000_0014, 1'b0, 5'h05);

        // T5: BTB aliasing at index 8
        do_reset();
        train(32'h20, 1'b1, 1'b0, 1'b1, 32'h80, 5'h00);
        train(32'hA0, 1'b1, 1'b0, 1'b1, 32'h200, 5'h00);
        look(32'h0000_0020, 32'h0000_0024, 1'b0, 5'h08);
        look(32'h0000_00A0, 32'h0000_0200, 1'b1, 5'h08);

        // T6: reset wins over a same-cycle update and clears earlier state
        train(32'h0, 1'b1, 1'b1, 1'b1, 32'h400, 5'h00);
        step(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 1'b1, 32'h80, 5'h00, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0);
        look(32'h0000_0020, 32'h0000_0024, 1'b0, 5'h08);
        look(32'h0000_00A0, 32'h0000_00A4, 1'b0, 5'h08);
        look(32'h0000_0000, 32'h0000_0004, 1'b0, 5'h00);

        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        if (look_id != 15) begin
            failures = failures + 1;
            $display("FAIL lookup_count issued=%0d required=15", look_id);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
